// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory port arbiter.
// FSM state enum, requester IDs and latency-counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_id_e;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// mem_arb_lat_cnt: loadable down-counter timing the memory latency.
// tc is high in the cycle the count steps down to zero.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOAD_VAL = 4'd2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign tc = dec && (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data.
// Define ARB_FAIR_EN to bound fetch starvation to STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  req_id_e           id_q, id_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              any_req;
  logic              pick_d;
  logic              fair_force;
  logic              lat_tc;

  assign any_req = if_req | d_req;
  assign pick_d  = d_req & ~fair_force;

`ifdef ARB_FAIR_EN
  localparam int STW = $clog2(STARVE_MAX + 1);

  logic [STW-1:0] starve_q, starve_d;

  assign fair_force = if_req && (starve_q == STW'(STARVE_MAX));

  // Only data grants made while fetch is waiting count toward starvation.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!if_req || !pick_d) begin
        starve_d = '0;
      end else if (starve_q != STW'(STARVE_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve;

  assign unused_starve = (STARVE_MAX != 0);
  assign fair_force    = 1'b0;
`endif

  mem_arb_lat_cnt #(
    .LOAD_VAL (CNT_W'(MEM_LAT))
  ) u_lat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == ISSUE),
    .dec   (state_q == WAIT),
    .tc    (lat_tc)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d        = pick_d ? REQ_D : REQ_IF;
          we_d        = pick_d & d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_d & d_we;
          mem_addr_d  = pick_d ? d_addr : if_addr;
          mem_wdata_d = pick_d ? d_wdata : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lat_tc) begin
          if (id_q == REQ_D) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= REQ_IF;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a
// reference model of service order, latency and memory contents.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_rdata, d_wdata;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          if_ack, d_ack, mem_en, mem_we, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ram     [256];
  logic          wr_v    [256];
  logic [DW-1:0] pipe    [LAT];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] m_if_rd, m_d_rd;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] seed(int i);
    if (i == 16) return 32'h2010_FFFF;
    return {8'(i), 8'(~i), 8'(i * 7 + 1), 8'h3C};
  endfunction

  function automatic logic [AW-1:0] a_of(int unsigned i);
    logic [7:0] w;
    w = i[7:0];
    return {22'b0, w, 2'b00};
  endfunction

  // Memory environment: read data appears exactly LAT cycles after mem_en.
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      pipe[0] <= (wr_v[mem_addr[9:2]] === 1'b1) ? ram[mem_addr[9:2]]
                                               : seed(int'(mem_addr[9:2]));
    end else begin
      pipe[0] <= '0;
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) begin
      ram[mem_addr[9:2]]  <= mem_wdata;
      wr_v[mem_addr[9:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests are presented in an IDLE cycle (cycle 0); acks are expected
  // LAT+2 later, a second queued grant follows LAT+3 cycles after the first.
  task automatic run_ep(input bit di, input logic [AW-1:0] ia,
                        input bit dd, input bit dwe,
                        input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    logic [AW-1:0] qa[$];
    bit            qwe[$];
    logic [DW-1:0] qwd[$];
    int            qt[$];
    logic [DW-1:0] e_if, e_d;
    int            t_if, t_d, g_if, g_d, n_en, n_ifa, n_da, last;
    bit            prev_en;
    t_if = -1; t_d = -1; g_if = -1; g_d = -1;
    n_en = 0; n_ifa = 0; n_da = 0; prev_en = 1'b0;
    e_if = m_if_rd;
    e_d  = m_d_rd;
    if (dd) begin
      qa.push_back(da); qwe.push_back(dwe); qwd.push_back(dwd);
      qt.push_back(1);
      t_d = LAT + 2;
      if (dwe) ref_mem[da[9:2]] = dwd;
      else e_d = ref_mem[da[9:2]];
    end
    if (di) begin
      qa.push_back(ia); qwe.push_back(1'b0); qwd.push_back('0);
      qt.push_back(dd ? LAT + 4 : 1);
      t_if = dd ? 2 * LAT + 5 : LAT + 2;
      e_if = ref_mem[ia[9:2]];
    end
    last = (t_if > t_d) ? t_if : t_d;
    m_if_rd = e_if;
    m_d_rd  = e_d;
    if_req = di; if_addr = ia;
    d_req = dd; d_we = dwe; d_addr = da; d_wdata = dwd;
    for (int c = 1; c <= last + 1; c++) begin
      tick();
      if (mem_en) begin
        n_en++;
        chk("mem_en_gap", {31'b0, prev_en}, 0);
        if (qa.size() > 0) begin
          chk("issue_cycle", c, qt[0]);
          chk("mem_addr", mem_addr, qa[0]);
          chk("mem_we", {31'b0, mem_we}, {31'b0, qwe[0]});
          if (qwe[0]) chk("mem_wdata", mem_wdata, qwd[0]);
          void'(qa.pop_front());
          void'(qwe.pop_front());
          void'(qwd.pop_front());
          void'(qt.pop_front());
        end
      end
      prev_en = mem_en;
      if (if_ack) begin
        n_ifa++; g_if = c;
        chk("if_rdata", if_rdata, e_if);
        if_req = 1'b0;
      end
      if (d_ack) begin
        n_da++; g_d = c;
        chk("d_rdata", d_rdata, e_d);
        d_req = 1'b0;
      end
      if (c == 1) chk("busy_on", {31'b0, busy}, 1);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("busy_off", {31'b0, busy}, 0);
    chk("n_mem_en", n_en, int'(di) + int'(dd));
    chk("if_ack_cycle", g_if, t_if);
    chk("d_ack_cycle", g_d, t_d);
    chk("n_if_ack", n_ifa, int'(di));
    chk("n_d_ack", n_da, int'(dd));
    chk("if_rdata_hold", if_rdata, m_if_rd);
    chk("d_rdata_hold", d_rdata, m_d_rd);
  endtask

  initial begin
    int cnt, g, n_ifa, acks;
    bit exp_if;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    m_if_rd = '0;
    m_d_rd  = '0;
    tick();
    tick();
    chk("rst_flags", {27'b0, if_ack, d_ack, mem_en, mem_we, busy}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    tick();

    run_ep(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
    chk("fetch_word", if_rdata, 32'h2010_FFFF);
    run_ep(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, '0);
    run_ep(1'b0, '0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    run_ep(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
    chk("store_readback", if_rdata, 32'hDEAD_BEEF);

    // Reset lands while a load sits in WAIT.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    tick();
    tick();
    chk("pre_rst_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    d_req = 1'b0;
    tick();
    chk("mid_rst_flags", {27'b0, if_ack, d_ack, mem_en, mem_we, busy}, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    m_if_rd = '0;
    m_d_rd  = '0;
    acks = 0;
    for (int c = 0; c < 2 * LAT + 3; c++) begin
      tick();
      acks += int'(if_ack) + int'(d_ack);
    end
    chk("rst_no_ack", acks, 0);
    chk("rst_idle", {31'b0, busy}, 0);
    run_ep(1'b0, '0, 1'b1, 1'b0, 32'h104, '0);

    // Continuous contention from both stages.
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = '0;
    cnt = 0; g = 0; n_ifa = 0;
    for (int c = 0; c < 8 * (LAT + 3) && g < 6; c++) begin
      tick();
      if (if_ack) n_ifa++;
      if (mem_en) begin
        exp_if = FAIR && (cnt == SMAX);
        chk("grant_order", mem_addr, exp_if ? 32'h40 : 32'h100);
        if (exp_if) cnt = 0;
        else if (cnt < SMAX) cnt++;
        g++;
      end
    end
    chk("starve_grants", g, 6);
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int c = 0; c < 4 * LAT + 10 && busy; c++) begin
      tick();
      if (if_ack) n_ifa++;
    end
    chk("starve_drain", {31'b0, busy}, 0);
    chk("starve_if_acks", n_ifa, FAIR ? 1 : 0);
    m_d_rd = ref_mem[64];
    if (FAIR) m_if_rd = ref_mem[16];

    for (int e = 0; e < 40; e++) begin
      int k;
      k = $urandom_range(1, 3);
      run_ep(k[0], a_of($urandom_range(0, 31)), k[1],
             1'($urandom_range(0, 1)), a_of($urandom_range(0, 31)),
             $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
